// File: rtl/regfile_pkg.sv
// Shared FSM encoding and default geometry for the soft-clear register file.
package regfile_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_clr_ctrl.sv
// Soft-clear sequencer: walks clr_ptr from 0 to DEPTH-1, one entry per cycle.
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic          busy,
  output logic [AW-1:0] clr_ptr,
  output logic          zero_en
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t state;

  // A clear request during a sweep is simply not looked at, so the sweep never restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      clr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          if (clr_ptr == LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + AW'(1);
          end
        end
      endcase
    end
  end

  assign zero_en = busy;

endmodule

// File: rtl/regfile_param_clr.sv
// Two-read/one-write register file with write bypass and a sequential soft clear.
// Optional macro REGFILE_ZERO_REG_EN makes entry 0 a hardwired zero register.
module regfile_param_clr
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    Sr1,
  input  logic [AW-1:0]    Sr2,
  output logic [WIDTH-1:0] rdData1,
  output logic [WIDTH-1:0] rdData2,
  input  logic             clear,
  output logic             busy,
  output logic             wr_err
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    clr_ptr;
  logic             zero_en;
  logic             zero_dst;
  logic             wr_ok;
  logic             wr_drop;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic zero_addr(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  regfile_clr_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .busy    (busy),
    .clr_ptr (clr_ptr),
    .zero_en (zero_en)
  );

  // Writes to the hardwired zero entry vanish silently; every other lost write is flagged.
  assign zero_dst = zero_addr(dr);
  assign wr_ok    = write && !busy && !clear && in_range(dr) && !zero_dst;
  assign wr_drop  = write && !zero_dst && (busy || clear || !in_range(dr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (zero_en) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[dr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_err <= 1'b0;
    else        wr_err <= wr_drop;
  end

  always_comb begin
    rdData1 = '0;
    if (!busy && in_range(Sr1) && !zero_addr(Sr1))
      rdData1 = (wr_ok && (Sr1 == dr)) ? wrData : mem[Sr1];
  end

  always_comb begin
    rdData2 = '0;
    if (!busy && in_range(Sr2) && !zero_addr(Sr2))
      rdData2 = (wr_ok && (Sr2 == dr)) ? wrData : mem[Sr2];
  end

endmodule

// File: tb/tb_regfile_param_clr.sv
// Scoreboard bench for regfile_param_clr (DEPTH=20) against an array-level reference model.
module tb_regfile_param_clr;

  localparam int WIDTH = 32;
  localparam int DEPTH = 20;
  localparam int AW    = $clog2(DEPTH);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             write = 1'b0;
  logic [AW-1:0]    dr = '0;
  logic [WIDTH-1:0] wrData = '0;
  logic [AW-1:0]    Sr1 = '0;
  logic [AW-1:0]    Sr2 = '0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] rdData1, rdData2;
  logic             busy, wr_err;

  regfile_param_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write(write), .dr(dr), .wrData(wrData),
    .Sr1(Sr1), .Sr2(Sr2), .rdData1(rdData1), .rdData2(rdData2),
    .clear(clear), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             b;
    logic             e;
    int               tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int tag = 0;

  // Reference model: a clear empties the whole array at once, then stays busy for DEPTH cycles.
  logic [WIDTH-1:0] m [DEPTH];
  int               left;
  logic             err;

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    left = 0;
    err  = 1'b0;
  endfunction

  function automatic logic wr_valid_now();
    return write && left == 0 && !clear && int'(dr) < DEPTH && !(ZR && dr == 0);
  endfunction

  function automatic logic [WIDTH-1:0] m_read(input int s);
    if (left > 0 || s >= DEPTH || (ZR && s == 0)) return '0;
    if (wr_valid_now() && int'(dr) == s) return wrData;
    return m[s];
  endfunction

  function automatic void m_step();
    logic nerr;
    nerr = write && !(ZR && dr == 0) && (left > 0 || clear || int'(dr) >= DEPTH);
    if (left > 0) begin
      left = left - 1;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      left = DEPTH;
    end else if (wr_valid_now()) begin
      m[int'(dr)] = wrData;
    end
    err = nerr;
  endfunction

  task automatic push_exp();
    exp_t x;
    x.r1  = m_read(int'(Sr1));
    x.r2  = m_read(int'(Sr2));
    x.b   = (left > 0);
    x.e   = err;
    x.tag = tag;
    tag++;
    q.push_back(x);
  endtask

  task automatic cyc(input logic w, input int d, input logic [WIDTH-1:0] wd,
                     input int s1, input int s2, input logic clr);
    write  = w;
    dr     = AW'(d);
    wrData = wd;
    Sr1    = AW'(s1);
    Sr2    = AW'(s2);
    clear  = clr;
    push_exp();
    @(posedge clk);
    if (reset) m_step();
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    write = 1'b0;
    clear = 1'b0;
    m_reset();
    for (int i = 0; i < n; i++) begin
      push_exp();
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i += 2) cyc(1'b0, 0, '0, i, (i + 1) % DEPTH, 1'b0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, i, $urandom, (i + 3) % DEPTH, i, 1'b0);
  endtask

  task automatic chk(input string name, input int t, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, t, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("rdData1", x.tag, rdData1, x.r1);
      chk("rdData2", x.tag, rdData2, x.r2);
      chk("busy", x.tag, WIDTH'(busy), WIDTH'(x.b));
      chk("wr_err", x.tag, WIDTH'(wr_err), WIDTH'(x.e));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", tag);
    $fatal(1, "bench timeout");
  end

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    do_reset(2);
    // First write lands on the first edge after release, then reads back.
    cyc(1'b1, 5, 32'hDEADBEEF, 5, 0, 1'b0);
    cyc(1'b0, 0, '0, 5, 5, 1'b0);
    // Same-cycle bypass on port 2.
    cyc(1'b1, 7, 32'h12345678, 5, 7, 1'b0);
    cyc(1'b0, 0, '0, 7, 7, 1'b0);
    // Entry 0 behaviour (ordinary or hardwired zero depending on build).
    cyc(1'b1, 0, 32'hFFFFFFFF, 0, 0, 1'b0);
    cyc(1'b0, 0, '0, 0, 5, 1'b0);
    // Out-of-range write and read.
    cyc(1'b1, 25, 32'hA5A5A5A5, 25, 31, 1'b0);
    cyc(1'b0, 0, '0, 25, 7, 1'b0);
    // Full sweep with reads, a write to 3, and an ignored re-clear mid-sweep.
    fill(DEPTH);
    readback();
    cyc(1'b0, 0, '0, 4, 3, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i == 6)       cyc(1'b1, 3, 32'h33333333, 3, 4, 1'b0);
      else if (i == 9)  cyc(1'b0, 0, '0, 1, 2, 1'b1);
      else              cyc(1'b0, 0, '0, i % DEPTH, (i * 7) % DEPTH, 1'b0);
    end
    readback();
    // Clear and write in the same cycle.
    fill(DEPTH);
    cyc(1'b1, 9, 32'h99999999, 9, 9, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 0, '0, 9, 8, 1'b0);
    readback();
    // Reset in the middle of a sweep.
    fill(DEPTH);
    cyc(1'b0, 0, '0, 1, 2, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 0, '0, 1, 2, 1'b0);
    do_reset(1);
    readback();
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, (1 << AW) - 1), $urandom,
          $urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1),
          ($urandom_range(0, 39) == 0));
    end
    write = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain cycle=%0d got=%0d expected=0", tag, q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
